mesi_isc_bus_monitor: RTL and testbench
=======================================

// Module: mesi_isc_bus_monitor
// PURPOSE
//  Synthesizable, parametrised protocol monitor for the MESI ISC main and coherence buses.
//  Sits beside mesi_isc and observes every port's bus signals without driving any of them.
//  - Tracks outstanding requests per CPU port.
//  - Flags handshake and timeout violations as sticky per-port error bits.
//  - Records the first error seen.
//  - Counts completed transactions, for coverage closure in silicon and in simulation.
// PARAMETERS
//  CPU_COUNT      4   number of CPU ports monitored (1..16)
//  ADDR_WIDTH     32  main/coherence address width
//  MBUS_CMD_WIDTH 3   main bus command width
//  CBUS_CMD_WIDTH 3   coherence bus command width
//  TIMEOUT        64  max cycles a main-bus request may wait for ack (>=2)
//  CNT_WIDTH      16  per-port completed-transaction counter width
// PORTS
//  clk          in   1                       system clock
//  rst          in   1                       synchronous, active-high reset
//  clr_i        in   1                       sync clear of sticky errors and first-error record
//  mbus_cmd_i   in   CPU_COUNT*MBUS_CMD_WIDTH  main bus commands, port p at [p*W +: W]
//  mbus_addr_i  in   CPU_COUNT*ADDR_WIDTH      main bus addresses
//  mbus_ack_i   in   CPU_COUNT                 main bus acks (mesi_isc outputs)
//  cbus_cmd_i   in   CPU_COUNT*CBUS_CMD_WIDTH  coherence bus commands (mesi_isc outputs)
//  cbus_addr_i  in   ADDR_WIDTH                shared coherence address
//  cbus_ack_i   in   CPU_COUNT                 coherence bus acks
//  err_o        out  CPU_COUNT*7               sticky error bits, port p at [p*7 +: 7]
//  err_valid_o  out  1                       high once any error has been recorded
//  err_port_o   out  $clog2(CPU_COUNT)       port of the first error
//  err_code_o   out  3                       bit index of the first error
//  txn_cnt_o    out  CPU_COUNT*CNT_WIDTH     per-port completed main-bus transactions, saturating
// BEHAVIOUR
//  Command encodings
//  - Main bus: NOP=0, WR=1, RD=2, WR_BROAD=3, RD_BROAD=4. Values 5..7 are illegal.
//  - Coherence bus: NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4.
//  Reset and clear
//  - rst high on a clk edge forces all outputs, counters and state to 0 / IDLE.
//  - rst dominates all other inputs, including a reset raised mid-transaction.
//  - clr_i zeroes err_o, err_valid_o, err_port_o and err_code_o.
//  - clr_i leaves port FSMs and txn_cnt_o unchanged.
//  - An error detected in the same cycle as clr_i is recorded, after the clear.
//  Per-port main-bus FSM (IDLE / WAIT)
//  - IDLE: cmd!=NOP and ack=0 -> WAIT; the monitor latches cmd and addr, and the wait counter is set to 1.
//  - IDLE: cmd!=NOP and ack=1 -> the transaction completes in that cycle; state stays IDLE.
//  - WAIT: ack=1 -> IDLE and the transaction completes.
//  - WAIT: ack=0 -> the wait counter increments, saturating at TIMEOUT.
//  - Completing a transaction increments txn_cnt (saturates at all-ones).
//  - After ack, a new request is legal in the very next cycle.
//  Error bits per port, set 1 cycle after the offending cycle
//  - [0] MBUS_UNSTABLE: in WAIT, cmd or addr differs from the latched value (including a drop to NOP).
//  - [1] MBUS_SPURIOUS_ACK: mbus_ack=1 while cmd==NOP.
//  - [2] MBUS_TIMEOUT: set once, when the wait counter reaches TIMEOUT with no ack.
//    The FSM remains in WAIT, so a later ack still completes the transaction.
//  - [3] CBUS_UNSTABLE: a coherence cmd!=NOP without ack must keep its cmd and cbus_addr_i next cycle.
//    Dropping it or changing it before ack sets this bit. Tracked by a per-port 1-bit pending flag.
//  - [4] CBUS_SPURIOUS_ACK: cbus_ack=1 while cbus cmd==NOP.
//  - [5] ACK_MULTI: more than one mbus_ack high in a cycle.
//    Set on the lowest-indexed acking port only.
//  - [6] ILLEGAL_CMD: mbus cmd value 5..7.
//    The port is still tracked as a request; the value is held as-is.
//  First-error record
//  - Captured only when err_valid_o==0.
//  - Simultaneous errors: lowest port wins, then lowest bit index.
//  - Holds until rst or clr_i.
//  Latency and width rules
//  - All outputs are registered; no combinational path from inputs to outputs.
//  - CPU_COUNT=1: err_port_o is 1 bit wide and always 0.
// TESTING
//  1. Port0 RD addr 0x100; ack 3 cycles later -> no errors; txn_cnt[0]=1; FSM back to IDLE.
//  2. Port2 WR addr 0x40; addr changes to 0x44 in cycle 2 -> err_o[2*7+0]=1; err_port_o=2; err_code_o=0.
//  3. Port1 RD with no ack for 64 cycles -> err_o[1*7+2] set in cycle 65, only once; a later ack gives txn_cnt[1]=1.
//  4. mbus_ack on ports 0 and 3 in the same cycle, both requesting -> ACK_MULTI on port 0 only; both counts increment.
//  5. cbus_ack1 with cbus_cmd1=NOP, same cycle as a port3 cmd=6 -> bits [1*7+4] and [3*7+6] both set; first error port=1, code=4.
//  6. Error pending, then clr_i together with a new spurious mbus ack on port0 -> only err_o[1] remains; err_code_o=1.
//  7. rst asserted while port0 is in WAIT -> next cycle all outputs are 0; the following ack on port0 sets SPURIOUS_ACK only if cmd==NOP.

Source files
------------

// File: rtl/mesi_isc_bus_monitor_if.sv
// Bundle of MESI ISC main and coherence bus signals seen by the monitor.
// master: the side driving the buses; slave: a passive observer such as the monitor.
interface mesi_isc_bus_monitor_if #(
    parameter int CPU_COUNT      = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int CBUS_CMD_WIDTH = 3
);
    logic [CPU_COUNT*MBUS_CMD_WIDTH-1:0] mbus_cmd_i;
    logic [CPU_COUNT*ADDR_WIDTH-1:0]     mbus_addr_i;
    logic [CPU_COUNT-1:0]                mbus_ack_i;
    logic [CPU_COUNT*CBUS_CMD_WIDTH-1:0] cbus_cmd_i;
    logic [ADDR_WIDTH-1:0]               cbus_addr_i;
    logic [CPU_COUNT-1:0]                cbus_ack_i;

    modport master (
        output mbus_cmd_i, mbus_addr_i, mbus_ack_i,
        output cbus_cmd_i, cbus_addr_i, cbus_ack_i
    );

    modport slave (
        input mbus_cmd_i, mbus_addr_i, mbus_ack_i,
        input cbus_cmd_i, cbus_addr_i, cbus_ack_i
    );
endinterface

// File: rtl/mesi_isc_bus_monitor.sv
// Passive protocol monitor for the MESI ISC main/coherence buses.
// Ports: clk, rst (sync, high), clr_i (clear errors), bus (observed buses),
// err_o (7 sticky bits per port), err_valid_o/err_port_o/err_code_o (first error),
// txn_cnt_o (saturating completed main-bus transactions per port). All outputs registered.
module mesi_isc_bus_monitor #(
    parameter int CPU_COUNT      = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int CBUS_CMD_WIDTH = 3,
    parameter int TIMEOUT        = 64,
    parameter int CNT_WIDTH      = 16,
    localparam int PW = (CPU_COUNT > 1) ? $clog2(CPU_COUNT) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr_i,
    mesi_isc_bus_monitor_if.slave          bus,
    output logic [CPU_COUNT*7-1:0]         err_o,
    output logic                           err_valid_o,
    output logic [PW-1:0]                  err_port_o,
    output logic [2:0]                     err_code_o,
    output logic [CPU_COUNT*CNT_WIDTH-1:0] txn_cnt_o
);
    localparam int MW  = MBUS_CMD_WIDTH;
    localparam int CW  = CBUS_CMD_WIDTH;
    localparam int AW  = ADDR_WIDTH;
    localparam int WCW = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t               state_q [CPU_COUNT];
    logic [MW-1:0]        cmd_q   [CPU_COUNT];
    logic [AW-1:0]        addr_q  [CPU_COUNT];
    logic [WCW-1:0]       wcnt_q  [CPU_COUNT];
    logic [CNT_WIDTH-1:0] cnt_q   [CPU_COUNT];
    logic [CW-1:0]        ccmd_q  [CPU_COUNT];
    logic [AW-1:0]        caddr_q [CPU_COUNT];
    logic [CPU_COUNT-1:0] cpend_q;

    logic [CPU_COUNT*7-1:0] err_q;
    logic                   ev_q;
    logic [PW-1:0]          port_q;
    logic [2:0]             code_q;

    logic [MW-1:0]          mcmd  [CPU_COUNT];
    logic [AW-1:0]          maddr [CPU_COUNT];
    logic [CW-1:0]          ccmd  [CPU_COUNT];
    logic [CPU_COUNT-1:0]   mack;
    logic [CPU_COUNT-1:0]   cack;
    logic [CPU_COUNT-1:0]   ack_low;
    logic                   ack_multi;
    logic [CPU_COUNT-1:0]   done;
    logic [CPU_COUNT*7-1:0] err_new;
    logic                   found;
    logic [PW-1:0]          fport;
    logic [2:0]             fcode;

    assign mack = bus.mbus_ack_i;
    assign cack = bus.cbus_ack_i;

    always_comb begin
        // Isolate the lowest set ack bit; more than one set bit is a multi-ack.
        ack_low   = mack & (~mack + CPU_COUNT'(1));
        ack_multi = (mack & (mack - CPU_COUNT'(1))) != '0;
        err_new   = '0;
        done      = '0;
        for (int p = 0; p < CPU_COUNT; p++) begin
            mcmd[p]  = bus.mbus_cmd_i[p*MW +: MW];
            maddr[p] = bus.mbus_addr_i[p*AW +: AW];
            ccmd[p]  = bus.cbus_cmd_i[p*CW +: CW];
            done[p]  = mack[p] && (state_q[p] == S_WAIT || mcmd[p] != '0);
            err_new[p*7+0] = (state_q[p] == S_WAIT) &&
                             (mcmd[p] != cmd_q[p] || maddr[p] != addr_q[p]);
            err_new[p*7+1] = mack[p] && (mcmd[p] == '0);
            // Counter saturates at TIMEOUT, so this fires only on the first crossing.
            err_new[p*7+2] = (state_q[p] == S_WAIT) && !mack[p] &&
                             (wcnt_q[p] == WCW'(TIMEOUT - 1));
            err_new[p*7+3] = cpend_q[p] &&
                             (ccmd[p] != ccmd_q[p] || bus.cbus_addr_i != caddr_q[p]);
            err_new[p*7+4] = cack[p] && (ccmd[p] == '0);
            err_new[p*7+5] = ack_multi && ack_low[p];
            err_new[p*7+6] = mcmd[p] > MW'(4);
        end
        found = 1'b0;
        fport = '0;
        fcode = '0;
        for (int p = 0; p < CPU_COUNT; p++) begin
            for (int b = 0; b < 7; b++) begin
                if (!found && err_new[p*7+b]) begin
                    found = 1'b1;
                    fport = PW'(p);
                    fcode = 3'(b);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < CPU_COUNT; p++) begin
                state_q[p] <= S_IDLE;
                cmd_q[p]   <= '0;
                addr_q[p]  <= '0;
                wcnt_q[p]  <= '0;
                cnt_q[p]   <= '0;
                ccmd_q[p]  <= '0;
                caddr_q[p] <= '0;
            end
            cpend_q <= '0;
            err_q   <= '0;
            ev_q    <= 1'b0;
            port_q  <= '0;
            code_q  <= '0;
        end else begin
            for (int p = 0; p < CPU_COUNT; p++) begin
                unique case (state_q[p])
                    S_IDLE: begin
                        if (mcmd[p] != '0 && !mack[p]) begin
                            state_q[p] <= S_WAIT;
                            cmd_q[p]   <= mcmd[p];
                            addr_q[p]  <= maddr[p];
                            wcnt_q[p]  <= WCW'(1);
                        end
                    end
                    S_WAIT: begin
                        if (mack[p]) begin
                            state_q[p] <= S_IDLE;
                        end else if (wcnt_q[p] != WCW'(TIMEOUT)) begin
                            wcnt_q[p] <= wcnt_q[p] + WCW'(1);
                        end
                    end
                endcase
                if (done[p] && cnt_q[p] != '1) begin
                    cnt_q[p] <= cnt_q[p] + CNT_WIDTH'(1);
                end
                cpend_q[p] <= (ccmd[p] != '0) && !cack[p];
                ccmd_q[p]  <= ccmd[p];
                caddr_q[p] <= bus.cbus_addr_i;
            end
            // Clear first, then fold in anything detected this same cycle.
            err_q <= (clr_i ? '0 : err_q) | err_new;
            if (clr_i || !ev_q) begin
                ev_q   <= found;
                port_q <= fport;
                code_q <= fcode;
            end
        end
    end

    always_comb begin
        txn_cnt_o = '0;
        for (int p = 0; p < CPU_COUNT; p++) begin
            txn_cnt_o[p*CNT_WIDTH +: CNT_WIDTH] = cnt_q[p];
        end
    end

    assign err_o       = err_q;
    assign err_valid_o = ev_q;
    assign err_port_o  = port_q;
    assign err_code_o  = code_q;
endmodule

// File: tb/tb_mesi_isc_bus_monitor.sv
// Directed bench for mesi_isc_bus_monitor with 4 ports, TIMEOUT 64.
// Expected values are hand-derived from the bus protocol rules.
module tb_mesi_isc_bus_monitor;
    logic        clk;
    logic        rst;
    logic        clr_i;
    logic [27:0] err_o;
    logic        err_valid_o;
    logic [1:0]  err_port_o;
    logic [2:0]  err_code_o;
    logic [63:0] txn_cnt_o;
    int          checks;
    int          errors;

    mesi_isc_bus_monitor_if #(
        .CPU_COUNT(4), .ADDR_WIDTH(32),
        .MBUS_CMD_WIDTH(3), .CBUS_CMD_WIDTH(3)
    ) bus ();

    mesi_isc_bus_monitor #(
        .CPU_COUNT(4), .ADDR_WIDTH(32), .MBUS_CMD_WIDTH(3),
        .CBUS_CMD_WIDTH(3), .TIMEOUT(64), .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr_i(clr_i),
        .bus(bus),
        .err_o(err_o),
        .err_valid_o(err_valid_o),
        .err_port_o(err_port_o),
        .err_code_o(err_code_o),
        .txn_cnt_o(txn_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] eb(input int p, input int b);
        logic [27:0] one;
        one = 28'd1;
        return one << (p * 7 + b);
    endfunction

    function automatic logic [63:0] tv(input int c0, input int c1, input int c2, input int c3);
        return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    endfunction

    task automatic mreq(input int p, input logic [2:0] c, input logic [31:0] a, input logic k);
        bus.mbus_cmd_i[p*3 +: 3]   = c;
        bus.mbus_addr_i[p*32 +: 32] = a;
        bus.mbus_ack_i[p]          = k;
    endtask

    task automatic creq(input int p, input logic [2:0] c, input logic k);
        bus.cbus_cmd_i[p*3 +: 3] = c;
        bus.cbus_ack_i[p]        = k;
    endtask

    task automatic clear();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clr_i  = 1'b0;
        bus.mbus_cmd_i  = '0;
        bus.mbus_addr_i = '0;
        bus.mbus_ack_i  = '0;
        bus.cbus_cmd_i  = '0;
        bus.cbus_addr_i = '0;
        bus.cbus_ack_i  = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_err", err_o, 0);
        chk("rst_valid", err_valid_o, 0);
        chk("rst_port", err_port_o, 0);
        chk("rst_code", err_code_o, 0);
        chk("rst_txn", txn_cnt_o, 0);

        // Port0 read, acked after waiting
        mreq(0, 3'd2, 32'h100, 1'b0);
        tick();
        chk("t1_txn_wait", txn_cnt_o, 0);
        tick();
        tick();
        mreq(0, 3'd2, 32'h100, 1'b1);
        tick();
        chk("t1_txn", txn_cnt_o, tv(1, 0, 0, 0));
        chk("t1_err", err_o, 0);
        mreq(0, 3'd0, 32'h0, 1'b0);
        tick();
        chk("t1_err_idle", err_o, 0);
        chk("t1_valid", err_valid_o, 0);

        // Port2 write with address change while waiting
        mreq(2, 3'd1, 32'h40, 1'b0);
        tick();
        mreq(2, 3'd1, 32'h44, 1'b0);
        tick();
        chk("t2_err", err_o, eb(2, 0));
        chk("t2_valid", err_valid_o, 1);
        chk("t2_port", err_port_o, 2);
        chk("t2_code", err_code_o, 0);
        mreq(2, 3'd1, 32'h44, 1'b1);
        tick();
        mreq(2, 3'd0, 32'h0, 1'b0);
        tick();
        chk("t2_txn", txn_cnt_o, tv(1, 0, 1, 0));
        clear();
        chk("clr_err", err_o, 0);
        chk("clr_valid", err_valid_o, 0);
        chk("clr_port", err_port_o, 0);
        chk("clr_code", err_code_o, 0);
        chk("clr_txn", txn_cnt_o, tv(1, 0, 1, 0));

        // Port1 timeout
        mreq(1, 3'd2, 32'h200, 1'b0);
        repeat (63) tick();
        chk("t3_pre", err_o, 0);
        tick();
        chk("t3_err", err_o, eb(1, 2));
        chk("t3_port", err_port_o, 1);
        chk("t3_code", err_code_o, 2);
        repeat (5) tick();
        chk("t3_hold", err_o, eb(1, 2));
        mreq(1, 3'd2, 32'h200, 1'b1);
        tick();
        chk("t3_txn", txn_cnt_o, tv(1, 1, 1, 0));
        mreq(1, 3'd0, 32'h0, 1'b0);
        tick();
        chk("t3_after", err_o, eb(1, 2));
        clear();

        // Simultaneous acks on ports 0 and 3
        mreq(0, 3'd1, 32'h10, 1'b1);
        mreq(3, 3'd2, 32'h30, 1'b1);
        tick();
        chk("t4_err", err_o, eb(0, 5));
        chk("t4_port", err_port_o, 0);
        chk("t4_code", err_code_o, 5);
        chk("t4_txn", txn_cnt_o, tv(2, 1, 1, 1));
        mreq(0, 3'd0, 32'h0, 1'b0);
        mreq(3, 3'd0, 32'h0, 1'b0);
        tick();
        clear();

        // Spurious cbus ack on port1 with illegal cmd on port3
        creq(1, 3'd0, 1'b1);
        mreq(3, 3'd6, 32'h60, 1'b0);
        tick();
        chk("t5_err", err_o, eb(1, 4) | eb(3, 6));
        chk("t5_port", err_port_o, 1);
        chk("t5_code", err_code_o, 4);
        creq(1, 3'd0, 1'b0);
        mreq(3, 3'd6, 32'h60, 1'b1);
        tick();
        mreq(3, 3'd0, 32'h0, 1'b0);
        tick();
        chk("t5_txn", txn_cnt_o, tv(2, 1, 1, 2));
        chk("t5_hold", err_o, eb(1, 4) | eb(3, 6));
        clear();

        // Coherence bus: held-until-ack is clean, early drop is not
        bus.cbus_addr_i = 32'h90;
        creq(1, 3'd2, 1'b0);
        tick();
        creq(1, 3'd2, 1'b1);
        tick();
        creq(1, 3'd0, 1'b0);
        tick();
        chk("cb_ok", err_o, 0);
        bus.cbus_addr_i = 32'hA0;
        creq(0, 3'd1, 1'b0);
        tick();
        creq(0, 3'd0, 1'b0);
        tick();
        chk("cb_drop", err_o, eb(0, 3));
        chk("cb_port", err_port_o, 0);
        chk("cb_code", err_code_o, 3);
        clear();

        // Clear coinciding with a new error
        creq(2, 3'd0, 1'b1);
        tick();
        creq(2, 3'd0, 1'b0);
        chk("t6_port0", err_port_o, 2);
        chk("t6_code0", err_code_o, 4);
        clr_i = 1'b1;
        mreq(0, 3'd0, 32'h0, 1'b1);
        tick();
        clr_i = 1'b0;
        mreq(0, 3'd0, 32'h0, 1'b0);
        chk("t6_err", err_o, eb(0, 1));
        chk("t6_valid", err_valid_o, 1);
        chk("t6_port", err_port_o, 0);
        chk("t6_code", err_code_o, 1);
        clear();

        // Reset while port0 waits
        mreq(0, 3'd2, 32'h100, 1'b0);
        tick();
        tick();
        mreq(3, 3'd0, 32'h0, 1'b1);
        tick();
        mreq(3, 3'd0, 32'h0, 1'b0);
        chk("t7_pre", err_o, eb(3, 1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t7_err", err_o, 0);
        chk("t7_valid", err_valid_o, 0);
        chk("t7_port", err_port_o, 0);
        chk("t7_code", err_code_o, 0);
        chk("t7_txn", txn_cnt_o, 0);
        mreq(0, 3'd2, 32'h100, 1'b1);
        tick();
        chk("t7_ack_txn", txn_cnt_o, tv(1, 0, 0, 0));
        chk("t7_ack_err", err_o, 0);
        mreq(0, 3'd0, 32'h0, 1'b1);
        tick();
        mreq(0, 3'd0, 32'h0, 1'b0);
        chk("t7_spur", err_o, eb(0, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
